// File: rtl/ahb_slave_rr_arbiter_pkg.sv
// rtl/ahb_slave_rr_arbiter_pkg.sv - shared FSM state type and default sizing for the slave arbiters
package AHB_package;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_MASTER_NUM = 3;
  localparam int DEF_MAX_BEATS  = 16;

endpackage

// File: rtl/ahb_slave_rr_arbiter_rr_pick.sv
// rtl/ahb_slave_rr_arbiter_rr_pick.sv - combinational cyclic priority search from ptr upward
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_rr_arbiter.sv
// rtl/ahb_slave_rr_arbiter.sv - round-robin tenure arbiter in front of one AHB slave
module ahb_slave_rr_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = DEF_MASTER_NUM,
  parameter int MAX_BEATS  = DEF_MAX_BEATS,
  parameter int ID_W       = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [MASTER_NUM-1:0] hlast,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [ID_W-1:0]       hmaster_id,
  output logic                  timeout
);

  localparam int                CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(MASTER_NUM - 1);

  arb_state_t            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_d;
  logic [ID_W-1:0]       id_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_d;

  logic [ID_W-1:0]       ptr_wrap;
  logic [ID_W-1:0]       pick_ptr;
  logic [MASTER_NUM-1:0] pick_req;
  logic [MASTER_NUM-1:0] pick;
  logic                  end_last, end_max, end_abort, tenure_end;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [MASTER_NUM-1:0] g);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (g[i]) r = r | ID_W'(i);
    end
    return r;
  endfunction

  // The outgoing owner is masked out at tenure end so it cannot re-win back-to-back.
  assign ptr_wrap   = (hmaster_id == ID_LAST) ? '0 : hmaster_id + ID_W'(1);
  assign pick_ptr   = (state_q == ST_BUSY) ? ptr_wrap : ptr_q;
  assign pick_req   = (state_q == ST_BUSY) ? (hreq & ~hgrant) : hreq;

  assign end_last   = hready & hlast[hmaster_id];
  assign end_max    = hready & (cnt_q == BEAT_LAST);
  assign end_abort  = ~hreq[hmaster_id];
  assign tenure_end = (state_q == ST_BUSY) & (end_last | end_max | end_abort);

  rr_pick #(
    .N  (MASTER_NUM),
    .PW (ID_W)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = hgrant;
    id_d      = hmaster_id;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|hreq) begin
          state_d = ST_BUSY;
          grant_d = pick;
          id_d    = onehot_to_id(pick);
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (tenure_end) begin
          ptr_d     = ptr_wrap;
          timeout_d = end_max & ~end_last;
          cnt_d     = '0;
          if (|pick) begin
            grant_d = pick;
            id_d    = onehot_to_id(pick);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end else if (hready && (cnt_q != BEAT_LAST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q    <= ST_IDLE;
      hgrant     <= '0;
      hmaster_id <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hgrant     <= grant_d;
      hmaster_id <= id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      timeout    <= timeout_d;
    end
  end

  assign hsel = |hgrant;

endmodule

// File: tb/tb_ahb_slave_rr_arbiter.sv
// tb/tb_ahb_slave_rr_arbiter.sv - scoreboard bench for ahb_slave_rr_arbiter against a tenure-level model
module tb_ahb_slave_rr_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 8;
  localparam int IW   = 2;

  logic          hclk = 1'b0;
  logic          hreset_n = 1'b0;
  logic [N-1:0]  hreq = '0;
  logic [N-1:0]  hlast = '0;
  logic          hready = 1'b0;
  logic [N-1:0]  hgrant;
  logic          hsel;
  logic [IW-1:0] hmaster_id;
  logic          timeout;

  ahb_slave_rr_arbiter #(
    .MASTER_NUM (N),
    .MAX_BEATS  (MAXB),
    .ID_W       (IW)
  ) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .hreq       (hreq),
    .hlast      (hlast),
    .hready     (hready),
    .hgrant     (hgrant),
    .hsel       (hsel),
    .hmaster_id (hmaster_id),
    .timeout    (timeout)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [IW-1:0] id;
    logic          t;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   timeouts_seen = 0;

  // Reference model: owner index (-1 = nobody), beats completed in the tenure, rr pointer.
  int owner_m = -1;
  int beats_m = 0;
  int ptr_m   = 0;

  function automatic int search(input logic [N-1:0] r, input int from, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    int   tmo;
    tmo = 0;
    if (owner_m < 0) begin
      if (hreq != '0) begin
        owner_m = search(hreq, ptr_m, -1);
        beats_m = 0;
      end
    end else begin
      bit a, b, c;
      a = hready && hlast[owner_m];
      b = hready && (beats_m + 1 == MAXB);
      c = !hreq[owner_m];
      if (a || b || c) begin
        tmo     = (b && !a) ? 1 : 0;
        ptr_m   = (owner_m + 1) % N;
        owner_m = search(hreq, ptr_m, owner_m);
        beats_m = 0;
      end else if (hready) begin
        beats_m = beats_m + 1;
      end
    end
    e.g  = (owner_m < 0) ? '0 : N'(1) << owner_m;
    e.id = (owner_m < 0) ? '0 : IW'(owner_m);
    e.t  = (tmo != 0);
    return e;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    @(negedge hclk);
    #1;
    hreq   = r;
    hlast  = l;
    hready = rd;
    exp_q.push_back(model_step());
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (hgrant !== '0 || hsel !== 1'b0 || hmaster_id !== '0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got hgrant=%b hsel=%b id=%0d timeout=%b, need all zero",
               name, hgrant, hsel, hmaster_id, timeout);
    end
  endtask

  task automatic pulse_reset(input logic [N-1:0] req_after);
    @(negedge hclk);
    #2;
    hreset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_tenure");
    owner_m = -1;
    beats_m = 0;
    ptr_m   = 0;
    @(negedge hclk);
    #1;
    hreq     = req_after;
    hreset_n = 1'b1;
  endtask

  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (timeout === 1'b1) timeouts_seen++;
      if (hgrant !== e.g || hmaster_id !== e.id || timeout !== e.t || hsel !== (|e.g)) begin
        miscompares++;
        $display("FAIL scoreboard @%0t: got hgrant=%b id=%0d timeout=%b hsel=%b, need hgrant=%b id=%0d timeout=%b hsel=%b",
                 $time, hgrant, hmaster_id, timeout, hsel, e.g, e.id, e.t, |e.g);
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    #3;
    check_reset_outputs("reset_initial");
    @(negedge hclk);
    #1;
    hreset_n = 1'b1;

    // Basic grant and release.
    step(3'b010, 3'b000, 1'b1);
    step(3'b010, 3'b010, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Rotation with two-beat tenures.
    step(3'b111, 3'b000, 1'b1);
    for (int i = 0; i < 8; i++) step(3'b111, (i % 2 == 1) ? 3'b111 : 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Beat-limit timeout with master 1 waiting.
    for (int i = 0; i < 11; i++) step(3'b011, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Wait states, then hlast on the final permitted beat.
    step(3'b001, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b001, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b001, 3'b001, 1'b0);
    for (int i = 0; i < 4; i++) step(3'b001, 3'b000, 1'b1);
    step(3'b001, 3'b001, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Abort mid-burst.
    step(3'b110, 3'b000, 1'b1);
    step(3'b110, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Reset while master 2 owns, then 3'b101 after release.
    step(3'b100, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    pulse_reset(3'b101);
    step(3'b101, 3'b000, 1'b1);
    step(3'b101, 3'b001, 1'b1);
    step(3'b000, 3'b000, 1'b1);

    // Randomized traffic with sticky requests.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] lst;
      for (int m = 0; m < N; m++) begin
        if (!rq[m]) rq[m] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 7) == 0) rq[m] = 1'b0;
        lst[m] = ($urandom_range(0, 3) == 0);
      end
      step(rq, lst, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge hclk);
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    vectors++;
    if (timeouts_seen == 0) begin
      miscompares++;
      $display("FAIL timeout_seen: got %0d pulses, need at least 1", timeouts_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
